// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared multi-cycle ALU: round-robin grant, operand hold, result/flag capture.
// Optional ADDS/SUBS architectural flag register enabled by defining ALU_ARB_FLAG_REG_EN.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_cntrl,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_cntrl,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  output logic             rsp_valid,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_cntrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  output logic [3:0]       flags_q
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_d;
  logic               rr_ptr, rr_ptr_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               rsp_valid_d, rsp_id_d, rsp_err_d;
  logic [WIDTH-1:0]   rsp_result_d, alu_A_d, alu_B_d;
  logic [3:0]         rsp_flags_d;
  logic [2:0]         alu_cntrl_d;

  logic               grant0, grant1, win_id, win_illegal;
  logic [2:0]         win_cntrl;
  logic [WIDTH-1:0]   win_A, win_B;

  // Single requester wins outright; on contention rr_ptr picks the port.
  assign grant0      = req0_valid & (~req1_valid | ~rr_ptr);
  assign grant1      = req1_valid & (~req0_valid |  rr_ptr);
  assign req0_ready  = (state == IDLE) & grant0;
  assign req1_ready  = (state == IDLE) & grant1;
  assign win_id      = grant1;
  assign win_cntrl   = win_id ? req1_cntrl : req0_cntrl;
  assign win_A       = win_id ? req1_A : req0_A;
  assign win_B       = win_id ? req1_B : req0_B;
  assign win_illegal = (win_cntrl == 3'b001) | (win_cntrl == 3'b111);

  always_comb begin
    state_d      = state;
    rr_ptr_d     = rr_ptr;
    cnt_d        = cnt;
    rsp_valid_d  = rsp_valid;
    rsp_id_d     = rsp_id;
    rsp_result_d = rsp_result;
    rsp_flags_d  = rsp_flags;
    rsp_err_d    = rsp_err;
    alu_A_d      = alu_A;
    alu_B_d      = alu_B;
    alu_cntrl_d  = alu_cntrl;
    unique case (state)
      IDLE: begin
        if (grant0 | grant1) begin
          rr_ptr_d = ~win_id;
          rsp_id_d = win_id;
          if (win_illegal) begin
            // Illegal opcodes never reach the ALU; answer immediately.
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_flags_d  = '0;
          end else begin
            state_d     = EXEC;
            cnt_d       = CNT_W'(ALU_LAT - 1);
            alu_A_d     = win_A;
            alu_B_d     = win_B;
            alu_cntrl_d = win_cntrl;
          end
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b0;
          rsp_result_d = alu_result;
          rsp_flags_d  = {alu_negative, alu_zero, alu_overflow, alu_carry_out};
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_cntrl  <= 3'b000;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      cnt        <= cnt_d;
      rsp_valid  <= rsp_valid_d;
      rsp_id     <= rsp_id_d;
      rsp_result <= rsp_result_d;
      rsp_flags  <= rsp_flags_d;
      rsp_err    <= rsp_err_d;
      alu_A      <= alu_A_d;
      alu_B      <= alu_B_d;
      alu_cntrl  <= alu_cntrl_d;
    end
  end

`ifdef ALU_ARB_FLAG_REG_EN
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Architectural NZVC: only execute-stage ADD/SUB results set the flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (rsp_valid & rsp_ready & ~rsp_err & ~rsp_id &
                 ((alu_cntrl == OP_ADD) | (alu_cntrl == OP_SUB))) begin
      flags_q <= rsp_flags;
    end
  end
`else
  assign flags_q = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural 64-bit ALU attached.
module tb_alu_arbiter;

`ifdef ALU_ARB_FLAG_REG_EN
  localparam logic [3:0] FQ_ADD = 4'b1010;
`else
  localparam logic [3:0] FQ_ADD = 4'b0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_cntrl, req1_cntrl, alu_cntrl;
  logic [63:0] req0_A, req0_B, req1_A, req1_B;
  logic        rsp_valid, rsp_id, rsp_ready, rsp_err;
  logic [63:0] rsp_result, alu_A, alu_B, alu_result;
  logic [3:0]  rsp_flags, flags_q;
  logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic [64:0] alu_sum;

  int total = 0;
  int bad   = 0;
  int lat, ng, nr;
  logic stale;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cntrl(req0_cntrl),
    .req0_A(req0_A), .req0_B(req0_B),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cntrl(req1_cntrl),
    .req1_A(req1_A), .req1_B(req1_B),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_A(alu_A), .alu_B(alu_B), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; SUB carry is the no-borrow carry of A + ~B + 1.
  always_comb begin
    alu_sum       = '0;
    alu_result    = '0;
    alu_overflow  = 1'b0;
    alu_carry_out = 1'b0;
    case (alu_cntrl)
      3'b000: alu_result = alu_B;
      3'b010: begin
        alu_sum       = {1'b0, alu_A} + {1'b0, alu_B};
        alu_result    = alu_sum[63:0];
        alu_carry_out = alu_sum[64];
        alu_overflow  = (alu_A[63] == alu_B[63]) && (alu_result[63] != alu_A[63]);
      end
      3'b011: begin
        alu_sum       = {1'b0, alu_A} + {1'b0, ~alu_B} + 65'd1;
        alu_result    = alu_sum[63:0];
        alu_carry_out = alu_sum[64];
        alu_overflow  = (alu_A[63] != alu_B[63]) && (alu_result[63] != alu_A[63]);
      end
      3'b100: alu_result = alu_A & alu_B;
      3'b101: alu_result = alu_A | alu_B;
      3'b110: alu_result = alu_A ^ alu_B;
      default: alu_result = '0;
    endcase
    alu_negative = alu_result[63];
    alu_zero     = (alu_result == 64'd0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for rsp_valid, checking the ALU operands are held meanwhile.
  task automatic wait_rsp(input logic [63:0] ea, input logic [63:0] eb,
                          input logic [2:0] eop, output int l);
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        l = i;
        break;
      end
      check("alu_a_hold", alu_A, ea);
      check("alu_b_hold", alu_B, eb);
      check("alu_op_hold", 64'(alu_cntrl), 64'(eop));
      @(posedge clk);
    end
    check("rsp_seen", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_cntrl = 3'b000; req0_A = '0; req0_B = '0;
    req1_valid = 1'b0; req1_cntrl = 3'b000; req1_A = '0; req1_B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_alu_a", alu_A, 64'd0);
    check("rst_alu_op", 64'(alu_cntrl), 64'd0);
    check("rst_flags_q", 64'(flags_q), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single ADD 1+1 on port 0
    req0_valid = 1'b1; req0_cntrl = 3'b010; req0_A = 64'd1; req0_B = 64'd1;
    @(negedge clk);
    check("single_r0_ready", 64'(req0_ready), 64'd1);
    check("single_r1_ready", 64'(req1_ready), 64'd0);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_rsp(64'd1, 64'd1, 3'b010, lat);
    check("single_lat", 64'(lat), 64'd3);
    check("single_id", 64'(rsp_id), 64'd0);
    check("single_result", rsp_result, 64'd2);
    check("single_flags", 64'(rsp_flags), 64'd0);
    check("single_err", 64'(rsp_err), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_done", 64'(rsp_valid), 64'd0);

    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    // Contention: grants alternate 0,1,0,1 from reset
    req0_valid = 1'b1; req0_cntrl = 3'b011; req0_A = 64'd5; req0_B = 64'd2;
    req1_valid = 1'b1; req1_cntrl = 3'b110;
    req1_A = 64'hFF00FF00FF00FF00; req1_B = 64'h0F0F0F0F0F0F0F0F;
    ng = 0; nr = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        check("cont_rsp_id", 64'(rsp_id), 64'(nr % 2));
        check("cont_result", rsp_result, (nr % 2 == 1) ? 64'hF00FF00FF00FF00F : 64'd3);
        nr++;
      end
      if (req0_ready | req1_ready) begin
        check("cont_onehot", 64'(req0_ready & req1_ready), 64'd0);
        check("cont_grant", 64'(req1_ready), 64'(ng % 2));
        ng++;
      end
    end
    check("cont_grants", 64'(ng), 64'd4);
    check("cont_rsps", 64'(nr), 64'd3);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("cont_drain", 64'(rsp_valid), 64'd0);

    // Backpressure with a pending request on port 0
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_cntrl = 3'b101; req1_A = 64'hF0; req1_B = 64'h0F;
    @(negedge clk);
    check("bp_r1_ready", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_cntrl = 3'b000; req0_A = 64'd0; req0_B = 64'h55;
    wait_rsp(64'hF0, 64'h0F, 3'b101, lat);
    check("bp_lat", 64'(lat), 64'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_result", rsp_result, 64'hFF);
      check("bp_flags", 64'(rsp_flags), 64'd0);
      check("bp_no_ready", 64'(req0_ready | req1_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_released", 64'(rsp_valid), 64'd0);
    check("bp_next_grant", 64'(req0_ready), 64'd1);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_rsp(64'd0, 64'h55, 3'b000, lat);
    check("bp2_lat", 64'(lat), 64'd3);
    check("bp2_id", 64'(rsp_id), 64'd0);
    check("bp2_result", rsp_result, 64'h55);
    check("bp2_flags", 64'(rsp_flags), 64'd0);
    @(posedge clk); #1;

    // Illegal opcode on port 1
    req1_valid = 1'b1; req1_cntrl = 3'b111; req1_A = 64'h1234; req1_B = 64'h5678;
    @(negedge clk);
    check("ill_r1_ready", 64'(req1_ready), 64'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp(64'd0, 64'h55, 3'b000, lat);
    check("ill_lat", 64'(lat), 64'd1);
    check("ill_err", 64'(rsp_err), 64'd1);
    check("ill_id", 64'(rsp_id), 64'd1);
    check("ill_result", rsp_result, 64'd0);
    check("ill_flags", 64'(rsp_flags), 64'd0);
    check("ill_alu_op", 64'(alu_cntrl), 64'd0);
    check("ill_alu_a", alu_A, 64'd0);
    @(posedge clk); #1;

    // Reset during the first EXEC cycle
    req0_valid = 1'b1; req0_cntrl = 3'b010; req0_A = 64'd3; req0_B = 64'd4;
    @(negedge clk);
    check("rme_r0_ready", 64'(req0_ready), 64'd1);
    @(posedge clk); #1 req0_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; req1_cntrl = 3'b010;
    @(negedge clk);
    check("rme_valid", 64'(rsp_valid), 64'd0);
    check("rme_rr_r0", 64'(req0_ready), 64'd1);
    check("rme_rr_r1", 64'(req1_ready), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      stale = stale | rsp_valid;
    end
    check("rme_no_stale", 64'(stale), 64'd0);

    // Flag register: ADD overflow on port 0 sets it, SUB on port 1 does not
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_cntrl = 3'b010; req0_A = 64'h7FFFFFFFFFFFFFFF; req0_B = 64'd1;
    @(negedge clk);
    check("fl_r0_ready", 64'(req0_ready), 64'd1);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_rsp(64'h7FFFFFFFFFFFFFFF, 64'd1, 3'b010, lat);
    check("fl_add_result", rsp_result, 64'h8000000000000000);
    check("fl_add_flags", 64'(rsp_flags), 64'hA);
    check("fl_q_pre", 64'(flags_q), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("fl_q_add", 64'(flags_q), 64'(FQ_ADD));
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_cntrl = 3'b011; req1_A = 64'd2; req1_B = 64'd5;
    @(negedge clk);
    check("fl_r1_ready", 64'(req1_ready), 64'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp(64'd2, 64'd5, 3'b011, lat);
    check("fl_sub_result", rsp_result, 64'hFFFFFFFFFFFFFFFD);
    check("fl_sub_flags", 64'(rsp_flags), 64'h8);
    check("fl_sub_id", 64'(rsp_id), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("fl_q_sub", 64'(flags_q), 64'(FQ_ADD));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 64-bit ALU between two requesters: port 0 is the execute stage and port 1 is the address/compare unit.
- Holds operands stable at the ALU for ALU_LAT cycles, because the gate-level ripple ALU needs multi-cycle settling. It then captures the result and the N/Z/V/C flags and returns them to the granted requester with a valid/ready handshake.
- The block is placed between the EX-stage requesters and the alu instance.

Parameters:
- WIDTH, 64, operand/result width.
- ALU_LAT, 2, cycles operands are held at the ALU before capture. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_cntrl  in  3  ALU opcode: 000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR.
- req0_A, req0_B  in  WIDTH  operands.
- req1_valid, req1_ready, req1_cntrl, req1_A, req1_B  same as port 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_id  out  1  requester the response belongs to.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_flags  out  4  {negative, zero, overflow, carry_out} as captured.
- rsp_err  out  1  opcode was illegal (001 or 111).
- alu_A, alu_B  out  WIDTH  drive the ALU inputs.
- alu_cntrl  out  3  drives the ALU opcode.
- alu_result  in  WIDTH  ALU result.
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1  ALU flags.
- flags_q  out  4  architectural NZVC register (see Optional Feature).

Behaviour:
- FSM states: IDLE, EXEC, RESP. All state is updated on the rising edge of clk.
- Reset: state=IDLE, rr_ptr=0, cycle counter=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0, alu_A=0, alu_B=0, alu_cntrl=000, flags_q=0.
  - A reset in EXEC or RESP abandons the operation. No response is emitted.
- IDLE arbitration:
  - If only one reqN_valid is high, that requester wins.
  - If both are high, the requester selected by rr_ptr wins.
  - req_ready is asserted combinationally, only in IDLE, and only to the winner.
  - On the handshake: latch A, B, cntrl and the winner id into the alu_* / id registers; set rr_ptr = ~winner; go to EXEC with counter=ALU_LAT-1.
- Illegal opcode handshake: no EXEC. Go directly to RESP with rsp_err=1, rsp_result=0, rsp_flags=0. alu_* registers are not updated.
- EXEC:
  - alu_A, alu_B and alu_cntrl stay constant.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: capture alu_result into rsp_result and the four flags into rsp_flags; set rsp_err=0; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result, rsp_flags and rsp_err are stable.
  - On rsp_ready=1, return to IDLE with rsp_valid=0.
  - No new grant is issued in the same cycle (one bubble cycle).
- Latency: handshake in cycle t gives rsp_valid=1 in cycle t+ALU_LAT+1. For an illegal opcode, rsp_valid=1 in cycle t+1.
- Throughput: at most one operation in flight. Neither req_ready is asserted outside IDLE.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1 starting from port 0 after reset.
- Flags for PASS_B, AND, OR and XOR are passed through exactly as the ALU supplies them. V and C are don't-care for consumers.

Optional Feature:
- Macro: ALU_ARB_FLAG_REG_EN.
- With the macro defined: flags_q is a register updated from rsp_flags on each rsp handshake (rsp_valid & rsp_ready) where the captured opcode was ADD or SUB and rsp_id=0. This models the ADDS/SUBS flag-setting path. All other responses leave flags_q unchanged. Reset value is 0.
- Without the macro: flags_q is tied to 4'b0000 and no flag register is synthesized.

Test Plan:
- Single request, ALU_LAT=2: req0 ADD A=1, B=1 in cycle t -> rsp_valid at t+3 with rsp_id=0, rsp_result=2, rsp_flags=0000. alu_A and alu_B stable through EXEC.
- Contention: both valid every cycle, req0 SUB 5-2 and req1 XOR FF00..FF00 ^ 0F0F..0F0F -> grants alternate 0,1,0,1. Results are 3 and F00FF00FF00FF00F respectively. Exactly one req_ready is high per grant.
- Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_result and rsp_flags unchanged, both req_ready=0. Releasing rsp_ready leads to the next grant one cycle later.
- Illegal opcode: req1 cntrl=111 -> rsp_valid=1 one cycle after the handshake, with rsp_err=1, rsp_result=0 and alu_cntrl unchanged.
- Reset mid-EXEC: assert reset during cycle 1 of EXEC -> next cycle state=IDLE, rsp_valid=0, rr_ptr=0, and no stale response afterwards.
- With ALU_ARB_FLAG_REG_EN: req0 ADD 7FFF_FFFF_FFFF_FFFF + 1 -> flags_q=1010 after the rsp handshake. A following req1 SUB 2-5 leaves flags_q=1010. Without the macro, flags_q=0000 throughout.
